// File: rtl/spi_ram_master.sv
// spi_ram_master: turns host RAM requests into two 10-bit SPI frames, plus a read-back phase for reads.
module spi_ram_master #(
    parameter int GAP_CYC = 1,
    parameter int RD_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS_n
);
    localparam int WMAX = GAP_CYC > RD_WAIT ? (GAP_CYC > 8 ? GAP_CYC : 8) : (RD_WAIT > 8 ? RD_WAIT : 8);
    localparam int CW = $clog2(WMAX + 1);
    typedef enum logic [2:0] {IDLE, SHIFT, GAP, RWAIT, RCAP, DONE} state_t;
    state_t state, nstate;
    logic [3:0] cnt, ncnt;
    logic [CW-1:0] wcnt, nwcnt;
    logic second, nsecond, we_q, nwe;
    logic [7:0] addr_q, naddr, wdata_q, nwdata, rdata_sh, nrdata;
    logic [9:0] nframe;
    always_comb begin
        nstate = state;
        ncnt = cnt;
        nwcnt = wcnt;
        nsecond = second;
        nwe = we_q;
        naddr = addr_q;
        nwdata = wdata_q;
        nrdata = rdata_sh;
        case (state)
            IDLE: if (req_valid && req_ready) begin
                nstate = SHIFT;
                ncnt = 4'd9;
                nsecond = 1'b0;
                nwe = req_we;
                naddr = req_addr;
                nwdata = req_wdata;
            end
            SHIFT: if (cnt != 4'd0) ncnt = cnt - 4'd1;
                else if (!second) begin
                    nstate = GAP;
                    nwcnt = CW'(GAP_CYC - 1);
                end else if (we_q) nstate = DONE;
                else if (RD_WAIT == 0) begin
                    nstate = RCAP;
                    nwcnt = CW'(7);
                end else begin
                    nstate = RWAIT;
                    nwcnt = CW'(RD_WAIT - 1);
                end
            GAP: if (wcnt == '0) begin
                nstate = SHIFT;
                ncnt = 4'd9;
                nsecond = 1'b1;
            end else nwcnt = wcnt - CW'(1);
            RWAIT: if (wcnt == '0) begin
                nstate = RCAP;
                nwcnt = CW'(7);
            end else nwcnt = wcnt - CW'(1);
            RCAP: begin
                nrdata = {rdata_sh[6:0], MISO};
                if (wcnt == '0) nstate = DONE;
                else nwcnt = wcnt - CW'(1);
            end
            DONE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
        // cmd[1] is 0 for writes, cmd[0] marks the second frame
        nframe = {~nwe, nsecond, nsecond ? (nwe ? nwdata : 8'h00) : naddr};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            wcnt <= '0;
            second <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_sh <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy <= 1'b0;
            MOSI <= 1'b0;
            SS_n <= 1'b1;
        end else begin
            state <= nstate;
            cnt <= ncnt;
            wcnt <= nwcnt;
            second <= nsecond;
            we_q <= nwe;
            addr_q <= naddr;
            wdata_q <= nwdata;
            rdata_sh <= nrdata;
            // outputs are registered from the next state so they line up with it
            req_ready <= nstate == IDLE;
            rsp_valid <= nstate == DONE;
            busy <= nstate != IDLE;
            MOSI <= (nstate == SHIFT) && nframe[ncnt];
            SS_n <= !(nstate inside {SHIFT, RWAIT, RCAP});
            if (nstate == DONE) rsp_rdata <= we_q ? 8'h00 : nrdata;
        end
    end
endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: table-driven and sequence checks of two configurations against an SPI RAM slave model.
module tb_spi_ram_master;
    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
    } vec_t;
    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
        int         acc;
    } sb_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_we = '0;
    logic [7:0] req_addr [2] = '{8'h00, 8'h00};
    logic [7:0] req_wdata [2] = '{8'h00, 8'h00};
    logic [7:0] exp_rd [2] = '{8'h00, 8'h00};
    logic [1:0] rdy, rsp_valid, busy, mosi, ss_n;
    logic [7:0] rsp_rdata [2];
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int GC = g ? 3 : 1;
        localparam int RW = g ? 0 : 2;
        logic miso = 1'b0;
        sb_t sbq[$];
        logic [9:0] frq[$];
        logic [7:0] mem [256];
        logic [7:0] saddr = 8'h00;
        logic [7:0] last_rd = 8'h00;
        logic [7:0] rb;
        logic [9:0] sh = '0;
        logic [9:0] f;
        logic rdp = 1'b0;
        logic rst_seen = 1'b0;
        int bitn = 0;
        int hi = 0;
        int gap_last = 0;
        int last_acc = 0;
        assign rb = mem[saddr];
        assign f = {sh[8:0], mosi[g]};
        initial for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
        spi_ram_master #(.GAP_CYC(GC), .RD_WAIT(RW)) dut (
            .clk(clk), .rst(rst), .req_valid(req_valid[g]), .req_ready(rdy[g]),
            .req_we(req_we[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .busy(busy[g]),
            .MOSI(mosi[g]), .MISO(miso), .SS_n(ss_n[g])
        );
        always @(posedge clk) begin
            rst_seen <= rst;
            if (rst) begin
                sbq.delete();
                frq.delete();
            end else if (req_valid[g] && rdy[g]) begin
                sbq.push_back('{req_we[g], req_addr[g], req_wdata[g], exp_rd[g], cyc + 1});
                last_acc <= cyc + 1;
            end
        end
        // slave: decodes frames into its own RAM and drives read data after RW wait cycles
        always @(negedge clk) begin
            if (ss_n[g]) begin
                hi <= hi + 1;
                bitn <= 0;
                rdp <= 1'b0;
                miso <= 1'b0;
            end else begin
                if (bitn == 0) begin
                    gap_last <= hi;
                    hi <= 0;
                end
                if (bitn < 10) sh <= f;
                if (bitn == 9) begin
                    frq.push_back(f);
                    case (f[9:8])
                        2'b00, 2'b10: saddr <= f[7:0];
                        2'b01: mem[saddr] <= f[7:0];
                        default: rdp <= 1'b1;
                    endcase
                end
                if (bitn >= 10) chk("mosi_low_after_frame", mosi[g], 0);
                miso <= (rdp && bitn >= 10 + RW && bitn < 18 + RW) ? rb[3'(17 + RW - bitn)] : 1'b0;
                bitn <= bitn + 1;
            end
        end
        always @(negedge clk) begin
            if (rst_seen) begin
                chk("rst_rdata", rsp_rdata[g], 0);
                last_rd <= 8'h00;
            end else if (rsp_valid[g]) begin
                if (sbq.size() == 0) chk("unexpected_rsp", rsp_valid[g], 0);
                else begin
                    chk("rsp_rdata", rsp_rdata[g], sbq[0].rd);
                    chk("rsp_latency", cyc + 1 - sbq[0].acc, sbq[0].we ? 21 + GC : 29 + GC + RW);
                    chk("busy_at_rsp", busy[g], 1);
                    chk("gap_len", gap_last, GC);
                    if (frq.size() >= 2) begin
                        chk("frame_addr", frq[0], {~sbq[0].we, 1'b0, sbq[0].addr});
                        chk("frame_data", frq[1], {~sbq[0].we, 1'b1, sbq[0].we ? sbq[0].wdata : 8'h00});
                        void'(frq.pop_front());
                        void'(frq.pop_front());
                    end else chk("frame_count", frq.size(), 2);
                    void'(sbq.pop_front());
                end
                last_rd <= rsp_rdata[g];
            end else chk("rdata_hold", rsp_rdata[g], last_rd);
        end
    end
    task automatic do_req(input int i, input logic we, input logic [7:0] addr, input logic [7:0] wd,
                          input logic [7:0] rd, input logic hold);
        int k = 0;
        @(negedge clk);
        req_we[i] = we;
        req_addr[i] = addr;
        req_wdata[i] = wd;
        exp_rd[i] = rd;
        req_valid[i] = 1'b1;
        while (!rdy[i] && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k == 200) chk("accept_timeout", rdy[i], 1);
        @(posedge clk);
        if (!hold) begin
            @(negedge clk);
            req_valid[i] = 1'b0;
        end
    endtask
    task automatic wait_idle(input int i);
        int k = 0;
        while (busy[i] && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", busy[i], 0);
    endtask
    initial begin
        vec_t tbl [8];
        int r;
        int seen;
        tbl = '{'{1'b1, 8'hFF, 8'hAA, 8'h00}, '{1'b0, 8'hFF, 8'h00, 8'hAA},
                '{1'b1, 8'h00, 8'h55, 8'h00}, '{1'b0, 8'h00, 8'h00, 8'h55},
                '{1'b1, 8'h80, 8'h01, 8'h00}, '{1'b0, 8'h80, 8'h00, 8'h01},
                '{1'b0, 8'h81, 8'h3C, 8'h7E}, '{1'b0, 8'h10, 8'h00, 8'hEF}};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ss_n", ss_n[i], 1);
            chk("rst_mosi", mosi[i], 0);
            chk("rst_rsp_valid", rsp_valid[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_ready", rdy[i], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("ready_after_rst", rdy[i], 1);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 8; k++) begin
                do_req(i, tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].rd, 1'b0);
                wait_idle(i);
            end
        // back-to-back: valid held from a write straight into a read
        do_req(0, 1'b1, 8'h44, 8'h5C, 8'h00, 1'b1);
        @(negedge clk);
        req_we[0] = 1'b0;
        req_addr[0] = 8'h44;
        req_wdata[0] = 8'h00;
        exp_rd[0] = 8'h5C;
        r = 0;
        while (!rsp_valid[0] && r < 100) begin
            @(negedge clk);
            r++;
        end
        r = cyc + 1;
        chk("b2b_ss_at_rsp", ss_n[0], 1);
        chk("b2b_ready_at_rsp", rdy[0], 0);
        @(negedge clk);
        chk("b2b_ss_idle", ss_n[0], 1);
        repeat (2) @(negedge clk);
        chk("b2b_accept_gap", u[0].last_acc - r, 1);
        req_valid[0] = 1'b0;
        wait_idle(0);
        // request lines churn while busy; the latched write must be unaffected
        do_req(0, 1'b1, 8'h33, 8'h96, 8'h00, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            req_valid[0] = ~req_valid[0];
            req_we[0] = 1'($urandom);
            req_addr[0] = 8'($urandom);
            req_wdata[0] = 8'($urandom);
            chk("ready_while_busy", rdy[0], 0);
        end
        req_valid[0] = 1'b0;
        wait_idle(0);
        do_req(0, 1'b0, 8'h33, 8'h00, 8'h96, 1'b0);
        wait_idle(0);
        // reset during bit 5 of the read-data frame
        do_req(0, 1'b0, 8'h81, 8'h00, 8'h7E, 1'b0);
        repeat (15) @(negedge clk);
        chk("bit5_ss_low", ss_n[0], 0);
        chk("bit5_mosi", mosi[0], 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ss_n", ss_n[0], 1);
        chk("midrst_mosi", mosi[0], 0);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_rsp_valid", rsp_valid[0], 0);
        chk("midrst_ready", rdy[0], 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", rdy[0], 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen += int'(rsp_valid[0]);
        end
        chk("midrst_no_rsp", seen, 0);
        do_req(0, 1'b1, 8'h01, 8'hC7, 8'h00, 1'b0);
        wait_idle(0);
        do_req(0, 1'b0, 8'h01, 8'h00, 8'hC7, 1'b0);
        wait_idle(0);
        repeat (3) @(negedge clk);
        chk("sb_empty0", u[0].sbq.size(), 0);
        chk("sb_empty1", u[1].sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_ram_master.md
SPI_RAM_MASTER -- requirements
Module: spi_ram_master

Interface
REQ-001 Parameter GAP_CYC, default 1: cycles SS_n is held high between the two frames of a transaction (legal range >= 1).
REQ-002 Parameter RD_WAIT, default 2: cycles between the last read-data command bit and the first MISO sample (legal range >= 0).
REQ-003 clk  input  1  single system clock; also clocks the attached SPI slave.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = RAM write, 0 = RAM read.
REQ-008 req_addr  input  8  RAM address.
REQ-009 req_wdata  input  8  write data; ignored for reads.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  8  read data, valid with rsp_valid; 0 for writes.
REQ-012 busy  output  1  high from acceptance through the rsp_valid cycle.
REQ-013 MOSI  output  1  serial command/data to the slave, MSB first.
REQ-014 MISO  input  1  serial read data from the slave, MSB first.
REQ-015 SS_n  output  1  active-low slave select.

Function
REQ-016 Each frame SHALL be 10 bits {cmd[1:0], payload[7:0]}, with one bit per clk, MSB first, and SS_n held low for the whole frame.
REQ-017 Command codes: 00 = write address, 01 = write data, 10 = read address, 11 = read data.
REQ-018 Write transaction: frame {00,addr}, then GAP_CYC cycles of SS_n high, then frame {01,wdata}.
REQ-019 Read transaction: frame {10,addr}, then GAP, then frame {11,8'h00}, then RD_WAIT cycles, then 8 MISO capture cycles.
REQ-020 During the RD_WAIT and capture cycles, SS_n SHALL stay low and MOSI SHALL be 0.
REQ-021 FSM states: IDLE, SHIFT, GAP, RWAIT, RCAP, DONE.
REQ-022 IDLE: req_ready = 1; a request is accepted when req_valid && req_ready; req_we, req_addr and req_wdata are latched on that edge; next state is SHIFT.
REQ-023 SHIFT: a 4-bit counter runs 9 down to 0 and MOSI = frame[count].
REQ-024 SHIFT exit, by the frame just completed:
- address frame: go to GAP;
- write-data frame: go to DONE;
- read-data frame: go to RWAIT, or to RCAP when RD_WAIT = 0.
REQ-025 GAP: SS_n = 1 and MOSI = 0 for GAP_CYC cycles, then SHIFT loads the second frame.
REQ-026 RCAP: on each of 8 edges, rdata_sh <= {rdata_sh[6:0], MISO}.
REQ-027 DONE: SS_n = 1 and rsp_valid = 1 for exactly one cycle, then IDLE.
REQ-028 req_ready SHALL be 0 in every state except IDLE; a request held through a busy period is accepted only on return to IDLE.
REQ-029 A request presented in the same cycle that DONE is active SHALL NOT be accepted; it is accepted the following cycle.
REQ-030 Timing, with acceptance edge at cycle T:
- first MOSI bit (cmd[1]) at T+1;
- write rsp_valid at T+21+GAP_CYC (T+22 with defaults);
- read rsp_valid at T+29+GAP_CYC+RD_WAIT (T+32 with defaults).
REQ-031 All outputs SHALL be registered, with no combinational path from MISO or req_* to any output.
REQ-032 rsp_rdata SHALL hold its value until the next rsp_valid.

Reset
REQ-033 While rst = 1, on the clock edge: state = IDLE, SS_n = 1, MOSI = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0, counters = 0.
REQ-034 req_ready SHALL be 0 while rst = 1 and 1 in the first cycle after rst falls.
REQ-035 Reset mid-transaction: SS_n goes high at the next edge, the transaction is discarded, and no rsp_valid is produced.
REQ-036 After a mid-transaction reset, the next request SHALL start a fresh frame from cmd[1].

Verification
REQ-037 Write addr=8'hFF, data=8'hAA -> MOSI carries 00_11111111, then SS_n high 1 cycle, then 01_10101010; rsp_valid at T+22 with rsp_rdata = 0.
REQ-038 Read addr=8'hFF with a slave model returning 8'hAA -> frames 10_11111111 and 11_00000000; rsp_valid at T+32 with rsp_rdata = 8'hAA.
REQ-039 Back-to-back: req_valid held high for a write then a read -> second acceptance exactly one cycle after the first rsp_valid; SS_n high in between.
REQ-040 rst pulsed during bit 5 of a read-data frame -> SS_n = 1 at the next edge, no rsp_valid, then a following write to addr=8'h01 completes normally.
REQ-041 Parameters GAP_CYC=3, RD_WAIT=0 -> gap is 3 cycles, first capture is the cycle after the last command bit, and read rsp_valid is at T+32.
REQ-042 req_valid toggling while busy -> ignored, req_ready = 0, and the latched addr/data are unchanged.
